// File: rtl/bsg_fifo_1r1w_rolly_replay_ctrl.sv
// Replay controller for a rolly FIFO: streams a packet speculatively, then commits on ack or
// rewinds and resends on nack/timeout, dropping the packet once the retry budget is spent.
module bsg_fifo_1r1w_rolly_replay_ctrl #(
  parameter int unsigned width_p     = 32,
  parameter int unsigned lg_size_p   = 2,
  parameter int unsigned pkt_len_p   = 4,
  parameter int unsigned max_retry_p = 3,
  parameter int unsigned timeout_p   = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [width_p-1:0]                 fifo_data_i,
  input  logic                               fifo_v_i,
  output logic                               fifo_yumi_o,
  output logic                               fifo_deq_v_o,
  output logic                               fifo_roll_v_o,
  output logic [width_p-1:0]                 link_data_o,
  output logic                               link_v_o,
  input  logic                               link_ready_i,
  input  logic                               link_ack_v_i,
  input  logic                               link_nack_v_i,
  output logic [$clog2(max_retry_p+1)-1:0]   retry_cnt_o,
  output logic                               drop_o
);

  localparam int unsigned beat_w_lp  = (pkt_len_p > 1) ? $clog2(pkt_len_p) : 1;
  localparam int unsigned tmo_w_lp   = $clog2(timeout_p);
  localparam int unsigned retry_w_lp = $clog2(max_retry_p + 1);

  localparam logic [beat_w_lp-1:0]  last_beat_lp = beat_w_lp'(pkt_len_p - 1);
  localparam logic [tmo_w_lp-1:0]   last_tmo_lp  = tmo_w_lp'(timeout_p - 1);
  localparam logic [retry_w_lp-1:0] max_retry_lp = retry_w_lp'(max_retry_p);

  // A packet must fit in the FIFO, otherwise it can never be rewound as a whole.
  if (pkt_len_p > (1 << lg_size_p)) begin : g_len_check
    $error("pkt_len_p exceeds rolly FIFO depth");
  end

  typedef enum logic [1:0] {StSend, StWait, StRoll} state_e;

  state_e                state_q, state_d;
  logic [beat_w_lp-1:0]  beat_q, beat_d;
  logic [tmo_w_lp-1:0]   tmo_q, tmo_d;
  logic [retry_w_lp-1:0] retry_q, retry_d;
  logic                  yumi;
  logic                  reject;

  assign link_data_o = fifo_data_i;
  assign retry_cnt_o = reset_i ? '0 : retry_q;

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    tmo_d         = tmo_q;
    retry_d       = retry_q;
    yumi          = 1'b0;
    reject        = 1'b0;
    link_v_o      = 1'b0;
    fifo_deq_v_o  = 1'b0;
    fifo_roll_v_o = 1'b0;
    drop_o        = 1'b0;

    unique case (state_q)
      StSend: begin
        link_v_o = fifo_v_i;
        yumi     = fifo_v_i & link_ready_i;
        if (yumi) begin
          if (beat_q == last_beat_lp) begin
            beat_d  = '0;
            tmo_d   = '0;
            state_d = StWait;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StWait: begin
        // nack wins over a simultaneous ack; timeout only counts when no ack arrives.
        reject = link_nack_v_i | (~link_ack_v_i & (tmo_q == last_tmo_lp));
        if (reject) begin
          if (retry_q < max_retry_lp) begin
            fifo_roll_v_o = 1'b1;
            retry_d       = retry_q + 1'b1;
            state_d       = StRoll;
          end else begin
            fifo_deq_v_o = 1'b1;
            drop_o       = 1'b1;
            retry_d      = '0;
            state_d      = StSend;
          end
        end else if (link_ack_v_i) begin
          fifo_deq_v_o = 1'b1;
          retry_d      = '0;
          state_d      = StSend;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StRoll: begin
        state_d = StSend;
      end
      default: begin
        state_d = StSend;
      end
    endcase

    fifo_yumi_o = yumi;
    if (reset_i) begin
      fifo_yumi_o   = 1'b0;
      link_v_o      = 1'b0;
      fifo_deq_v_o  = 1'b0;
      fifo_roll_v_o = 1'b0;
      drop_o        = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StSend;
      beat_q  <= '0;
      tmo_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
    end
  end

endmodule

// File: doc/bsg_fifo_1r1w_rolly_replay_ctrl.md
BSG_FIFO_1R1W_ROLLY_REPLAY_CTRL -- requirements
Module: bsg_fifo_1r1w_rolly_replay_ctrl

Interface
REQ-001 The block SHALL have parameter width_p, default 32, meaning beat width in bits.
REQ-002 The block SHALL have parameter lg_size_p, default 2, meaning log2 depth of the attached rolly FIFO.
REQ-003 The block SHALL have parameter pkt_len_p, default 4, meaning beats per packet; legal range 1 <= pkt_len_p <= 2**lg_size_p.
REQ-004 The block SHALL have parameter max_retry_p, default 3, meaning replays allowed before a packet is dropped; legal range >= 1.
REQ-005 The block SHALL have parameter timeout_p, default 16, meaning WAIT cycles before an implicit nack; legal range >= 2.
REQ-006 The block SHALL have one clock, clk_i, and a synchronous active-high reset, reset_i.
REQ-007 Port clk_i, input, 1 bit: clock.
REQ-008 Port reset_i, input, 1 bit: synchronous active-high reset.
REQ-009 Port fifo_data_i, input, width_p bits: FIFO read data.
REQ-010 Port fifo_v_i, input, 1 bit: FIFO read data valid.
REQ-011 Port fifo_yumi_o, output, 1 bit: speculative read pop.
REQ-012 Port fifo_deq_v_o, output, 1 bit: commit reads to FIFO.
REQ-013 Port fifo_roll_v_o, output, 1 bit: rewind reads to last commit.
REQ-014 Port link_data_o, output, width_p bits: beat to downstream link.
REQ-015 Port link_v_o, output, 1 bit: beat valid.
REQ-016 Port link_ready_i, input, 1 bit: link accepts beat.
REQ-017 Port link_ack_v_i, input, 1 bit: packet acknowledged.
REQ-018 Port link_nack_v_i, input, 1 bit: packet rejected.
REQ-019 Port retry_cnt_o, output, $clog2(max_retry_p+1) bits: replays of current packet.
REQ-020 Port drop_o, output, 1 bit: one-cycle pulse on packet drop.

Function
REQ-021 The FSM SHALL have states SEND, WAIT and ROLL.
REQ-022 In SEND: link_v_o=fifo_v_i; link_data_o=fifo_data_i (combinational); fifo_yumi_o=fifo_v_i & link_ready_i.
REQ-023 In SEND, the beat counter SHALL increment on each yumi; on the yumi of beat pkt_len_p-1 it SHALL clear to 0 and the state SHALL go to WAIT next cycle.
REQ-024 Outside SEND, link_v_o and fifo_yumi_o SHALL be 0.
REQ-025 In WAIT, the timeout counter SHALL start at 0 on entry and increment each cycle.
REQ-026 WAIT with ack=1 and nack=0: fifo_deq_v_o=1 that cycle; retry_cnt clears to 0; next state SEND.
REQ-027 WAIT with nack=1 (ack ignored), or timeout counter == timeout_p-1 with no ack: this is a reject.
REQ-028 On a reject with retry_cnt < max_retry_p: fifo_roll_v_o=1 that cycle; retry_cnt increments; next state ROLL.
REQ-029 On a reject with retry_cnt == max_retry_p: fifo_deq_v_o=1 and drop_o=1 that cycle; retry_cnt clears; next state SEND.
REQ-030 ROLL SHALL last exactly one cycle, with no yumi/deq/roll asserted, then go to SEND; it covers FIFO rewind latency.
REQ-031 ack/nack outside WAIT SHALL be ignored.
REQ-032 fifo_deq_v_o and fifo_roll_v_o SHALL never be asserted in the same cycle; each SHALL be at most one cycle per packet attempt.
REQ-033 The beat counter SHALL be max(1,$clog2(pkt_len_p)) bits and the timeout counter $clog2(timeout_p) bits; neither SHALL wrap within a state.

Reset
REQ-034 While reset_i=1 the state SHALL become SEND and all counters 0; next edge registers are reset values.
REQ-035 While reset_i=1: fifo_yumi_o, fifo_deq_v_o, fifo_roll_v_o, link_v_o, drop_o = 0; retry_cnt_o = 0.
REQ-036 Reset asserted mid-packet or in WAIT SHALL abandon the packet without a deq or roll pulse; the FIFO is reset alongside by integration.

Verification
REQ-037 Happy path: FIFO holds A0..A3, ready=1, ack on the 2nd WAIT cycle -> 4 consecutive yumi/link beats A0..A3, then one deq pulse, retry_cnt_o=0.
REQ-038 Single nack: nack in WAIT -> roll pulse, retry_cnt_o=1, one ROLL cycle, then A0..A3 re-sent; ack -> deq pulse, retry_cnt_o=0.
REQ-039 Timeout: no ack/nack -> roll pulse exactly 16 cycles after WAIT entry (timeout_p=16).
REQ-040 Drop: 4 consecutive nacks (max_retry_p=3) -> 3 roll pulses, then deq=1 and drop_o=1 in the same cycle; the next packet B0 is sent.
REQ-041 Backpressure and simultaneous events: ready toggling 1/0 -> no beat lost or duplicated; ack and nack in the same cycle -> roll, not deq; ack during SEND -> ignored.
REQ-042 Reset in WAIT after 4 beats -> no deq/roll pulse; all outputs 0 next cycle; state is SEND.
